picrom_server: RTL
==================

Name: picrom_server

Overview:
- Responder end of the picture-ROM read interface; consumes the picture index, pixel address and invert flag issued by the picture-selection and pixel-addressing logic.
- Returns the 12-bit RGB (4:4:4, Nexys4 VGA DAC) for that pixel through a fixed two-cycle pipeline.
- Owns the picture memory. After reset it fills the memory with a default pattern, then serves reads.
- While serving, it accepts pixel rewrites through a valid/ready write port.

Parameters:
- PIC_W, 4: picture index width; 2^PIC_W pictures.
- ADDR_W, 8: pixel address width within a picture (16x16).
- DATA_W, 12: RGB word width.

Ports:
- vgaclk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-low reset.
- index_to_ROM  in  PIC_W  picture select.
- addr_to_ROM  in  ADDR_W  pixel address: {row[3:0], col[3:0]}.
- inv_to_ROM  in  1  invert colour of the returned pixel.
- pixel_en  in  1  active-video qualifier for this request.
- rgb  out  DATA_W  pixel colour.
- rgb_valid  out  1  rgb corresponds to an enabled request.
- init_done  out  1  memory fill complete; serving reads and writes.
- wr_valid  in  1  write request.
- wr_ready  out  1  write can be accepted this cycle.
- wr_index  in  PIC_W  picture to write.
- wr_addr  in  ADDR_W  pixel to write.
- wr_data  in  DATA_W  colour to write.

Behaviour:
- Memory:
  - Simple dual-port, 2^(PIC_W+ADDR_W) x DATA_W (4096 x 12).
  - Read address and write address are both {index, addr}.
  - Synchronous read, read-first: a read and a write to the same location in the same cycle return the old data.
- Reset (reset==0 at a vgaclk edge):
  - rgb=0, rgb_valid=0, init_done=0, wr_ready=0.
  - All pipeline registers cleared; FSM enters INIT with fill counter=0.
  - Reset asserted mid-INIT or mid-SERVE restarts the fill from location 0.
  - Memory contents are not cleared by reset itself, only by the refill.
- FSM states:
  - INIT: each cycle write location fill_cnt with data = fill_cnt[DATA_W-1:0], i.e. {index, row, col}; fill_cnt increments.
  - INIT to SERVE: after writing location 4095 (4096 cycles).
  - SERVE: terminal until reset.
  - init_done is registered and rises on the first SERVE cycle.
- Read pipeline (SERVE only):
  - Cycle 0: inputs sampled.
  - Cycle 1: memory read issued; inv and pixel_en delayed alongside.
  - Cycle 2: rgb = inv ? ~mem_data : mem_data, rgb_valid = pixel_en.
  - Latency is exactly 2 vgaclk edges, fully pipelined, one request per cycle.
  - Blanking: when the delayed pixel_en==0, rgb=0 and rgb_valid=0 regardless of inv.
  - During INIT: rgb=0 and rgb_valid=0; input requests are discarded and not queued.
- Write port:
  - wr_ready = (state==SERVE), registered.
  - A write is accepted when wr_valid && wr_ready; the memory is written on that edge.
  - No backpressure in SERVE; a write is accepted every cycle.
  - The new data is visible to reads sampled on the following cycle or later.
  - wr_valid during INIT is ignored; the requester holds it until wr_ready.
- Width rules:
  - Inversion is bitwise over all DATA_W bits.
  - Addresses are concatenated, never added; no wrap logic is needed beyond the counter rolling over at the INIT end.

Decomposition:
- Shared package picrom_pkg holds:
  - PIC_W, ADDR_W, DATA_W;
  - MEM_DEPTH = 2^(PIC_W+ADDR_W);
  - state encoding {INIT, SERVE};
  - BLANK_RGB = 12'h000.
- One sub-module, picrom_mem: an inferable simple dual-port read-first BRAM with ports we, waddr, wdata, raddr, rdata.
- Top level holds the FSM, fill counter, read pipeline and write-port gating.

Test Plan:
- Fill timing:
  - Stimulus: release reset, idle inputs.
  - Response: init_done=0 for exactly 4096 cycles then 1; wr_ready rises in the same cycle as init_done; rgb=0 and rgb_valid=0 throughout INIT.
- Default readback with latency:
  - Stimulus: after init, index=4'h3, addr=8'hA5, inv=0, pixel_en=1.
  - Response: two edges later rgb=12'h3A5, rgb_valid=1.
- Invert:
  - Stimulus: as above with inv=1.
  - Response: rgb=12'hC5A.
- Blanking and streaming:
  - Stimulus: back-to-back addr 0..255 on index 0 with pixel_en toggling every cycle.
  - Response: rgb tracks addr with 2-cycle delay on enabled cycles; rgb=0 and rgb_valid=0 on disabled cycles.
- Write and read collision:
  - Stimulus: write 12'hF00 to (index 1, addr 8'h10) while reading the same location in the same cycle.
  - Response: that read returns 12'h110; a read one cycle later returns 12'hF00.
- Reset mid-operation:
  - Stimulus: assert reset at fill count 2000, and separately during SERVE after a write.
  - Response: outputs zero at the next edge; the fill restarts and takes a full 4096 cycles; the previously written location reads its default value again (12'h110).

Source files
------------

// File: rtl/picrom_pkg.sv
// rtl/picrom_pkg.sv - shared widths, state encoding and address helper for the picture ROM server
package picrom_pkg;

    localparam int PIC_W     = 4;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 12;
    localparam int MEM_AW    = PIC_W + ADDR_W;
    localparam int MEM_DEPTH = 1 << MEM_AW;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_SERVE = 1'b1;

    localparam logic [DATA_W-1:0] BLANK_RGB = 12'h000;
    localparam logic [MEM_AW-1:0] FILL_LAST = MEM_AW'(MEM_DEPTH - 1);

    // Picture and pixel address are concatenated, never added.
    function automatic logic [MEM_AW-1:0] pix_addr(input logic [PIC_W-1:0] idx,
                                                   input logic [ADDR_W-1:0] addr);
        return {idx, addr};
    endfunction

endpackage

// File: rtl/picrom_if.sv
// rtl/picrom_if.sv - read request/response and pixel write bundle between requester and picture ROM
interface picrom_if;
    import picrom_pkg::*;

    logic [PIC_W-1:0]  index_to_ROM;
    logic [ADDR_W-1:0] addr_to_ROM;
    logic              inv_to_ROM;
    logic              pixel_en;
    logic [DATA_W-1:0] rgb;
    logic              rgb_valid;
    logic              init_done;
    logic              wr_valid;
    logic              wr_ready;
    logic [PIC_W-1:0]  wr_index;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output index_to_ROM, addr_to_ROM, inv_to_ROM, pixel_en,
        output wr_valid, wr_index, wr_addr, wr_data,
        input  rgb, rgb_valid, init_done, wr_ready
    );

    modport slave (
        input  index_to_ROM, addr_to_ROM, inv_to_ROM, pixel_en,
        input  wr_valid, wr_index, wr_addr, wr_data,
        output rgb, rgb_valid, init_done, wr_ready
    );

endinterface

// File: rtl/picrom_mem.sv
// rtl/picrom_mem.sv - simple dual-port read-first block RAM holding all pictures
module picrom_mem
    import picrom_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = DATA_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Read samples the array before this edge's write lands: same-address collisions return old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/picrom_server.sv
// rtl/picrom_server.sv - picture ROM responder: default fill after reset, then 2-cycle pixel reads and pixel writes
module picrom_server
    import picrom_pkg::*;
(
    input  logic     vgaclk,
    input  logic     reset,
    picrom_if.slave  bus
);

    logic [0:0]        state;
    logic [MEM_AW-1:0] fill_cnt;
    logic              init_done_q;
    logic              wr_ready_q;
    logic              inv_d;
    logic              en_d;
    logic [DATA_W-1:0] rgb_q;
    logic              rgb_valid_q;

    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              wr_fire;

    assign wr_fire = bus.wr_valid && wr_ready_q;

    // Fill has priority; the write port is closed during INIT anyway.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = pix_addr(bus.wr_index, bus.wr_addr);
        mem_wdata = bus.wr_data;
        if (reset) begin
            if (state == ST_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = fill_cnt;
                mem_wdata = fill_cnt[DATA_W-1:0];
            end else begin
                mem_we    = wr_fire;
            end
        end
    end

    picrom_mem #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_mem (
        .clk   (vgaclk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (pix_addr(bus.index_to_ROM, bus.addr_to_ROM)),
        .rdata (mem_rdata)
    );

    always_ff @(posedge vgaclk) begin
        if (!reset) begin
            state       <= ST_INIT;
            fill_cnt    <= '0;
            init_done_q <= 1'b0;
            wr_ready_q  <= 1'b0;
        end else if (state == ST_INIT) begin
            fill_cnt <= fill_cnt + MEM_AW'(1);
            if (fill_cnt == FILL_LAST) begin
                state       <= ST_SERVE;
                init_done_q <= 1'b1;
                wr_ready_q  <= 1'b1;
            end
        end
    end

    // Requests arriving outside SERVE are dropped at the sampling edge, never queued.
    always_ff @(posedge vgaclk) begin
        if (!reset) begin
            inv_d       <= 1'b0;
            en_d        <= 1'b0;
            rgb_q       <= BLANK_RGB;
            rgb_valid_q <= 1'b0;
        end else begin
            inv_d       <= bus.inv_to_ROM;
            en_d        <= bus.pixel_en && (state == ST_SERVE);
            rgb_valid_q <= en_d;
            if (en_d) begin
                rgb_q <= inv_d ? ~mem_rdata : mem_rdata;
            end else begin
                rgb_q <= BLANK_RGB;
            end
        end
    end

    assign bus.rgb       = rgb_q;
    assign bus.rgb_valid = rgb_valid_q;
    assign bus.init_done = init_done_q;
    assign bus.wr_ready  = wr_ready_q;

endmodule
